// File: rtl/vga_ca_scroller_if.sv
// Pixel-position, control and video-output bundle between the hvsync generator,
// the CA renderer and the RGB mapping.
interface vga_ca_scroller_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        video_active;
  logic [7:0]  rule_in;
  logic        wrap_en;
  logic        rand_seed;
  logic        reseed;
  logic        scroll_en;
  logic        cell_on;
  logic [5:0]  rgb;
  logic [15:0] generation;

  modport master (
    output pix_x, pix_y, video_active, rule_in, wrap_en, rand_seed, reseed, scroll_en,
    input  cell_on, rgb, generation
  );

  modport slave (
    input  pix_x, pix_y, video_active, rule_in, wrap_en, rand_seed, reseed, scroll_en,
    output cell_on, rgb, generation
  );
endinterface

// File: rtl/vga_ca_scroller.sv
// Elementary 1D cellular-automaton renderer: one row register stepped in parallel per
// cell-row, a top row reseeded or scrolled once per frame, and a registered pixel output.
module vga_ca_scroller #(
  parameter int          GRID_W     = 160,
  parameter int          LOG_CELL   = 2,
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          PAD_LEFT   = (H_ACTIVE - (GRID_W << LOG_CELL)) / 2,
  parameter int          SCROLL_DIV = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_ca_scroller_if.slave   bus
);

  localparam int IDX_W = $clog2(GRID_W);
  localparam int FC_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [GRID_W-1:0] SEED_ROW  = {{(GRID_W-1){1'b0}}, 1'b1} << (GRID_W / 2);
  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(SCROLL_DIV - 1);

  logic [GRID_W-1:0] cur_row_q, cur_row_d;
  logic [GRID_W-1:0] top_row_q, top_row_d;
  logic [GRID_W-1:0] rand_sr_q, rand_sr_d;
  logic [7:0]        rule_q, rule_d;
  logic [15:0]       gen_q, gen_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              reseed_pend_q, reseed_pend_d;
  logic              cell_on_q, cell_on_d;
  logic [5:0]        rgb_q, rgb_d;

  // One generation step; the extended vector carries the boundary neighbours.
  function automatic logic [GRID_W-1:0] ca_step(input logic [GRID_W-1:0] row,
                                                input logic [7:0]        rule,
                                                input logic              wrap);
    logic [GRID_W+1:0] ext;
    logic [GRID_W-1:0] nxt;
    ext = {wrap & row[0], row, wrap & row[GRID_W-1]};
    for (int k = 0; k < GRID_W; k++) begin
      nxt[k] = rule[{ext[k], ext[k+1], ext[k+2]}];
    end
    return nxt;
  endfunction

  logic [10:0]       rel_x;
  logic [10:0]       cell_x;
  logic [IDX_W-1:0]  cell_idx;
  logic              in_grid;
  logic              lit;
  logic              row_evt;
  logic              frame_evt;
  logic [5:0]        col;
  logic [GRID_W-1:0] next_cur;
  logic [GRID_W-1:0] next_top;

  // A borrow out of the subtraction marks pixels left of the grid.
  assign rel_x     = {1'b0, bus.pix_x} - 11'(PAD_LEFT);
  assign cell_x    = rel_x >> LOG_CELL;
  assign cell_idx  = cell_x[IDX_W-1:0];
  assign in_grid   = bus.video_active && !rel_x[10] && (cell_x < 11'(GRID_W));
  assign lit       = in_grid && cur_row_q[cell_idx];
  assign row_evt   = (bus.pix_x == 10'(H_ACTIVE)) && (&bus.pix_y[LOG_CELL-1:0])
                     && (bus.pix_y < 10'(V_ACTIVE - 1));
  assign frame_evt = (bus.pix_x == 10'd0) && (bus.pix_y == 10'(V_ACTIVE));
  assign col       = (rule_q[6:1] == 6'd0) ? 6'b111111 : rule_q[6:1];
  assign next_cur  = ca_step(cur_row_q, rule_q, bus.wrap_en);
  assign next_top  = ca_step(top_row_q, rule_q, bus.wrap_en);

  always_comb begin
    // NOTE: every _d starts from a default so no branch leaves it unassigned (no latch).
    cur_row_d     = cur_row_q;
    top_row_d     = top_row_q;
    rule_d        = rule_q;
    gen_d         = gen_q;
    frame_cnt_d   = frame_cnt_q;
    reseed_pend_d = reseed_pend_q | bus.reseed;
    lfsr_d        = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    rand_sr_d     = {rand_sr_q[GRID_W-2:0], lfsr_q[0]};
    cell_on_d     = lit;
    rgb_d         = lit ? col : 6'd0;

    if (row_evt) begin
      cur_row_d = next_cur;
    end

    if (frame_evt) begin
      rule_d        = bus.rule_in;
      // A reseed arriving on the frame event itself waits for the next one.
      reseed_pend_d = bus.reseed;
      if (reseed_pend_q) begin
        top_row_d   = bus.rand_seed ? rand_sr_q : SEED_ROW;
        gen_d       = 16'd0;
        frame_cnt_d = '0;
      end else if (bus.scroll_en && (frame_cnt_q == FC_LAST)) begin
        top_row_d   = next_top;
        gen_d       = gen_q + 16'd1;
        frame_cnt_d = '0;
      end else if (bus.scroll_en) begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
      cur_row_d = top_row_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked logic; the row registers are ordinary
    // flops (not RAM), so they take the reset like everything else.
    if (!rst_n) begin
      cur_row_q     <= SEED_ROW;
      top_row_q     <= SEED_ROW;
      rand_sr_q     <= '0;
      rule_q        <= 8'd30;
      gen_q         <= 16'd0;
      lfsr_q        <= LFSR_SEED;
      frame_cnt_q   <= '0;
      reseed_pend_q <= 1'b0;
      cell_on_q     <= 1'b0;
      rgb_q         <= 6'd0;
    end else begin
      cur_row_q     <= cur_row_d;
      top_row_q     <= top_row_d;
      rand_sr_q     <= rand_sr_d;
      rule_q        <= rule_d;
      gen_q         <= gen_d;
      lfsr_q        <= lfsr_d;
      frame_cnt_q   <= frame_cnt_d;
      reseed_pend_q <= reseed_pend_d;
      cell_on_q     <= cell_on_d;
      rgb_q         <= rgb_d;
    end
  end

  assign bus.cell_on    = cell_on_q;
  assign bus.rgb        = rgb_q;
  assign bus.generation = gen_q;

endmodule

// File: tb/tb_vga_ca_scroller.sv
// Directed bench for vga_ca_scroller: compressed raster (only the pixels and event
// positions of interest are driven), with a second instance at SCROLL_DIV=3.
module tb_vga_ca_scroller;
  localparam int GW = 160;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_ca_scroller_if bus ();
  vga_ca_scroller_if bus3 ();

  assign bus3.pix_x        = bus.pix_x;
  assign bus3.pix_y        = bus.pix_y;
  assign bus3.video_active = bus.video_active;
  assign bus3.rule_in      = bus.rule_in;
  assign bus3.wrap_en      = bus.wrap_en;
  assign bus3.rand_seed    = bus.rand_seed;
  assign bus3.reseed       = bus.reseed;
  assign bus3.scroll_en    = bus.scroll_en;

  vga_ca_scroller dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  vga_ca_scroller #(.SCROLL_DIV(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int checks = 0;
  int errors = 0;

  // Reference random source: 16-bit Galois LFSR (taps B400) feeding a 160-bit shift register.
  logic [15:0]   lfsr_m;
  logic [GW-1:0] sr_m;
  logic [GW-1:0] snap_m;
  always @(posedge clk) begin
    if (!rst_n) begin
      lfsr_m <= 16'hACE1;
      sr_m   <= '0;
    end else begin
      lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
      sr_m   <= {sr_m[GW-2:0], lfsr_m[0]};
    end
  end

  function automatic logic [GW-1:0] ca_model(input logic [GW-1:0] r, input logic [7:0] rule,
                                             input bit wrap);
    logic [GW-1:0] res;
    logic lv, rv;
    for (int k = 0; k < GW; k++) begin
      lv = (k == 0 && !wrap) ? 1'b0 : r[(k + GW - 1) % GW];
      rv = (k == GW - 1 && !wrap) ? 1'b0 : r[(k + 1) % GW];
      res[k] = rule[{lv, r[k], rv}];
    end
    return res;
  endfunction

  function automatic logic [GW-1:0] one_hot(input int k);
    logic [GW-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    bus.pix_x        = 10'd700;
    bus.pix_y        = 10'd0;
    bus.video_active = 1'b0;
  endtask

  task automatic px(input int x, input int y, input bit va);
    bus.pix_x        = 10'(x);
    bus.pix_y        = 10'(y);
    bus.video_active = va;
    step();
  endtask

  task automatic frame_event(input bit rs);
    snap_m     = sr_m;
    bus.reseed = rs;
    px(0, 480, 1'b0);
    bus.reseed = 1'b0;
    park();
  endtask

  task automatic row_event(input int y);
    px(640, y, 1'b0);
    park();
  endtask

  task automatic advance_rows(input int n);
    for (int i = 0; i < n; i++) row_event(4 * i + 3);
  endtask

  task automatic scan_row(input int y, output logic [GW-1:0] obs);
    for (int k = 0; k < GW; k++) begin
      px(4 * k + 1, y, 1'b1);
      obs[k] = bus.cell_on;
    end
    park();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    park();
    bus.rule_in = 8'd90; bus.wrap_en = 1'b0; bus.rand_seed = 1'b0;
    bus.reseed = 1'b0;   bus.scroll_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    checks++; if (bus.cell_on !== 1'b0) begin errors++; $display("FAIL rst_cell_on got %b exp 0", bus.cell_on); end
    checks++; if (bus.rgb !== 6'd0) begin errors++; $display("FAIL rst_rgb got %b exp 000000", bus.rgb); end
    checks++; if (bus.generation !== 16'd0) begin errors++; $display("FAIL rst_gen got %0d exp 0", bus.generation); end
    checks++; if (bus3.generation !== 16'd0) begin errors++; $display("FAIL rst_gen3 got %0d exp 0", bus3.generation); end
    px(320, 0, 1'b1);
    checks++; if (bus.cell_on !== 1'b1) begin errors++; $display("FAIL rst_seed_cell got %b exp 1", bus.cell_on); end
    checks++; if (bus.rgb !== 6'b001111) begin errors++; $display("FAIL rst_rule30_rgb got %b exp 001111", bus.rgb); end
    park();
  endtask

  task automatic test_rule90();
    logic [GW-1:0] obs;
    logic [GW-1:0] exp;
    frame_event(1'b0);
    scan_row(0, obs);
    exp = one_hot(80);
    checks++; if (obs !== exp) begin errors++; $display("FAIL t1_row0 got %h exp %h", obs, exp); end
    px(320, 1, 1'b1);
    checks++; if (bus.cell_on !== 1'b1) begin errors++; $display("FAIL t1_px320 got %b exp 1", bus.cell_on); end
    checks++; if (bus.rgb !== 6'b101101) begin errors++; $display("FAIL t1_rgb90 got %b exp 101101", bus.rgb); end
    px(323, 1, 1'b1);
    checks++; if (bus.cell_on !== 1'b1) begin errors++; $display("FAIL t1_px323 got %b exp 1", bus.cell_on); end
    px(324, 1, 1'b1);
    checks++; if (bus.cell_on !== 1'b0) begin errors++; $display("FAIL t1_px324 got %b exp 0", bus.cell_on); end
    px(319, 1, 1'b1);
    checks++; if (bus.cell_on !== 1'b0) begin errors++; $display("FAIL t1_px319 got %b exp 0", bus.cell_on); end
    px(320, 1, 1'b0);
    checks++; if (bus.cell_on !== 1'b0) begin errors++; $display("FAIL t1_blank got %b exp 0", bus.cell_on); end
    checks++; if (bus.rgb !== 6'd0) begin errors++; $display("FAIL t1_blank_rgb got %b exp 000000", bus.rgb); end
    park();
    row_event(3);
    scan_row(4, obs);
    exp = one_hot(79) | one_hot(81);
    checks++; if (obs !== exp) begin errors++; $display("FAIL t1_row1 got %h exp %h", obs, exp); end
    row_event(7);
    scan_row(8, obs);
    exp = one_hot(78) | one_hot(82);
    checks++; if (obs !== exp) begin errors++; $display("FAIL t1_row2 got %h exp %h", obs, exp); end
  endtask

  task automatic test_wrap();
    logic [GW-1:0] obs;
    logic [GW-1:0] exp;
    do_reset();
    bus.rule_in = 8'd2;
    bus.wrap_en = 1'b1;
    frame_event(1'b0);
    advance_rows(80);
    scan_row(320, obs);
    exp = one_hot(0);
    checks++; if (obs !== exp) begin errors++; $display("FAIL t2_row80_wrap got %h exp %h", obs, exp); end
    row_event(323);
    scan_row(324, obs);
    exp = one_hot(159);
    checks++; if (obs !== exp) begin errors++; $display("FAIL t2_row81_wrap got %h exp %h", obs, exp); end
    bus.wrap_en = 1'b0;
    frame_event(1'b0);
    advance_rows(81);
    scan_row(324, obs);
    exp = '0;
    checks++; if (obs !== exp) begin errors++; $display("FAIL t2_row81_zero got %h exp %h", obs, exp); end
  endtask

  task automatic test_scroll();
    logic [GW-1:0] obs;
    logic [GW-1:0] exp;
    do_reset();
    bus.rule_in = 8'd90;
    bus.wrap_en = 1'b0;
    frame_event(1'b0);
    bus.scroll_en = 1'b1;
    frame_event(1'b0);
    frame_event(1'b0);
    checks++; if (bus.generation !== 16'd2) begin errors++; $display("FAIL t3_gen2 got %0d exp 2", bus.generation); end
    checks++; if (bus3.generation !== 16'd0) begin errors++; $display("FAIL t3_div3_gen_f2 got %0d exp 0", bus3.generation); end
    scan_row(0, obs);
    exp = one_hot(78) | one_hot(82);
    checks++; if (obs !== exp) begin errors++; $display("FAIL t3_row0 got %h exp %h", obs, exp); end
    frame_event(1'b0);
    checks++; if (bus3.generation !== 16'd1) begin errors++; $display("FAIL t3_div3_gen_f3 got %0d exp 1", bus3.generation); end
    frame_event(1'b0);
    frame_event(1'b0);
    frame_event(1'b0);
    checks++; if (bus3.generation !== 16'd2) begin errors++; $display("FAIL t3_div3_gen_f6 got %0d exp 2", bus3.generation); end
    checks++; if (bus.generation !== 16'd6) begin errors++; $display("FAIL t3_gen6 got %0d exp 6", bus.generation); end
    bus.scroll_en = 1'b0;
  endtask

  task automatic test_rule_change();
    logic [GW-1:0] obs;
    logic [GW-1:0] exp;
    do_reset();
    bus.rule_in = 8'd90;
    frame_event(1'b0);
    exp = one_hot(80);
    for (int i = 0; i < 25; i++) exp = ca_model(exp, 8'd90, 1'b0);
    advance_rows(25);
    bus.rule_in = 8'd30;
    scan_row(100, obs);
    checks++; if (obs !== exp) begin errors++; $display("FAIL t4_row25 got %h exp %h", obs, exp); end
    px(420, 101, 1'b1);
    checks++; if (bus.rgb !== 6'b101101) begin errors++; $display("FAIL t4_rgb_row25 got %b exp 101101", bus.rgb); end
    park();
    row_event(103);
    exp = ca_model(exp, 8'd90, 1'b0);
    scan_row(104, obs);
    checks++; if (obs !== exp) begin errors++; $display("FAIL t4_row26 got %h exp %h", obs, exp); end
    px(424, 105, 1'b1);
    checks++; if (bus.rgb !== 6'b101101) begin errors++; $display("FAIL t4_rgb_row26 got %b exp 101101", bus.rgb); end
    park();
    frame_event(1'b0);
    px(320, 0, 1'b1);
    checks++; if (bus.rgb !== 6'b001111) begin errors++; $display("FAIL t4_rgb_next_frame got %b exp 001111", bus.rgb); end
    park();
  endtask

  task automatic test_random_reseed();
    logic [GW-1:0] obs;
    logic [GW-1:0] exp;
    logic [GW-1:0] snap;
    do_reset();
    bus.rule_in   = 8'd90;
    bus.wrap_en   = 1'b0;
    bus.scroll_en = 1'b1;
    frame_event(1'b0);
    frame_event(1'b0);
    checks++; if (bus.generation !== 16'd2) begin errors++; $display("FAIL t5_gen_before got %0d exp 2", bus.generation); end
    scan_row(50, obs);
    bus.rand_seed = 1'b1;
    bus.pix_y     = 10'd50;
    bus.reseed    = 1'b1;
    step();
    bus.reseed    = 1'b0;
    repeat (37) step();
    frame_event(1'b0);
    snap = snap_m;
    checks++; if (bus.generation !== 16'd0) begin errors++; $display("FAIL t5_gen_reseed got %0d exp 0", bus.generation); end
    scan_row(0, obs);
    checks++; if (obs !== snap) begin errors++; $display("FAIL t5_rand_row0 got %h exp %h", obs, snap); end
    bus.rand_seed = 1'b0;
    frame_event(1'b1);
    checks++; if (bus.generation !== 16'd1) begin errors++; $display("FAIL t5_coincide_gen got %0d exp 1", bus.generation); end
    scan_row(0, obs);
    exp = ca_model(snap, 8'd90, 1'b0);
    checks++; if (obs !== exp) begin errors++; $display("FAIL t5_coincide_row0 got %h exp %h", obs, exp); end
    frame_event(1'b0);
    checks++; if (bus.generation !== 16'd0) begin errors++; $display("FAIL t5_deferred_gen got %0d exp 0", bus.generation); end
    scan_row(0, obs);
    exp = one_hot(80);
    checks++; if (obs !== exp) begin errors++; $display("FAIL t5_deferred_row0 got %h exp %h", obs, exp); end
    bus.scroll_en = 1'b0;
  endtask

  task automatic test_mid_frame_reset();
    logic [GW-1:0] obs;
    logic [GW-1:0] exp;
    do_reset();
    bus.rule_in = 8'd90;
    frame_event(1'b0);
    bus.scroll_en = 1'b1;
    frame_event(1'b0);
    frame_event(1'b0);
    px(312, 199, 1'b1);
    checks++; if (bus.cell_on !== 1'b1) begin errors++; $display("FAIL t6_pre_cell got %b exp 1", bus.cell_on); end
    rst_n = 1'b0;
    px(312, 200, 1'b1);
    rst_n = 1'b1;
    checks++; if (bus.cell_on !== 1'b0) begin errors++; $display("FAIL t6_cell_on got %b exp 0", bus.cell_on); end
    checks++; if (bus.rgb !== 6'd0) begin errors++; $display("FAIL t6_rgb got %b exp 000000", bus.rgb); end
    checks++; if (bus.generation !== 16'd0) begin errors++; $display("FAIL t6_gen got %0d exp 0", bus.generation); end
    checks++; if (bus3.generation !== 16'd0) begin errors++; $display("FAIL t6_gen3 got %0d exp 0", bus3.generation); end
    scan_row(200, obs);
    exp = one_hot(80);
    checks++; if (obs !== exp) begin errors++; $display("FAIL t6_seed_row got %h exp %h", obs, exp); end
    px(320, 201, 1'b1);
    checks++; if (bus.rgb !== 6'b001111) begin errors++; $display("FAIL t6_rule30_rgb got %b exp 001111", bus.rgb); end
    park();
    bus.scroll_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rule90();
    test_wrap();
    test_scroll();
    test_rule_change();
    test_random_reseed();
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
